gascon_lin_seq: RTL

GASCON_LIN_SEQ -- requirements
Module: gascon_lin_seq

---
 rtl/gascon_lin_seq_pkg.sv | 55 +++++
 rtl/gascon_lin_word.sv | 18 +
 rtl/gascon_lin_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/gascon_lin_seq_pkg.sv
// Shared DryGASCON linear-layer constants: word count, per-word rotate
// amounts, FSM encodings and the bit-interleaved rotate helper.
package gascon_lin_seq_pkg;

  localparam int NWORDS_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // First rotate amount (interleaved) per state word.
  function automatic logic [5:0] rot_a(input logic [2:0] idx);
    case (idx)
      3'd0:    rot_a = 6'd19;
      3'd1:    rot_a = 6'd61;
      3'd2:    rot_a = 6'd1;
      3'd3:    rot_a = 6'd10;
      3'd4:    rot_a = 6'd7;
      default: rot_a = 6'd0;
    endcase
  endfunction

  // Second rotate amount (interleaved) per state word.
  function automatic logic [5:0] rot_b(input logic [2:0] idx);
    case (idx)
      3'd0:    rot_b = 6'd28;
      3'd1:    rot_b = 6'd38;
      3'd2:    rot_b = 6'd6;
      3'd3:    rot_b = 6'd17;
      3'd4:    rot_b = 6'd40;
      default: rot_b = 6'd0;
    endcase
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] s);
    rotr32 = (v >> s) | (v << (5'd0 - s));
  endfunction

  // Rotate of a bit-interleaved word: low half holds even bits, high half
  // odd bits. An odd amount moves bits between halves.
  function automatic logic [63:0] birotr(input logic [63:0] x, input logic [5:0] r);
    logic [4:0] s0;
    logic [4:0] s1;
    s0 = r[5:1];
    s1 = r[5:1] + 5'd1;
    if (r[0]) begin
      birotr = {rotr32(x[31:0], s1), rotr32(x[63:32], s0)};
    end else begin
      birotr = {rotr32(x[63:32], s0), rotr32(x[31:0], s0)};
    end
  endfunction

endpackage

// File: rtl/gascon_lin_word.sv
// One-word GASCON linear diffusion: x ^ birotr(x,a) ^ birotr(x,b).
module gascon_lin_word
  import gascon_lin_seq_pkg::*;
(
  input  logic [63:0] x,
  input  logic [5:0]  amt_a,
  input  logic [5:0]  amt_b,
  output logic [63:0] y
);

  logic [63:0] rot_x_a;
  logic [63:0] rot_x_b;

  assign rot_x_a = birotr(x, amt_a);
  assign rot_x_b = birotr(x, amt_b);
  assign y       = x ^ rot_x_a ^ rot_x_b;

endmodule

// File: rtl/gascon_lin_seq.sv
// Sequential GASCON linear layer: one word per cycle through a single
// shared diffusion unit, with valid/ready handshakes on both sides.
module gascon_lin_seq
  import gascon_lin_seq_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [64*NWORDS-1:0]  in_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*NWORDS-1:0]  out_state,
  output logic                  busy
);

  state_t                state, state_nx;
  logic [2:0]            cnt, cnt_nx;
  logic [64*NWORDS-1:0]  data, data_nx;
  logic [63:0]           cur_word;
  logic [63:0]           lin_out;
  logic [5:0]            amt_a;
  logic [5:0]            amt_b;

  assign amt_a = rot_a(cnt);
  assign amt_b = rot_b(cnt);

  gascon_lin_word u_lin_word (
    .x     (cur_word),
    .amt_a (amt_a),
    .amt_b (amt_b),
    .y     (lin_out)
  );

  // Select the word addressed by the counter for the shared diffusion unit.
  always_comb begin
    cur_word = 64'd0;
    for (int i = 0; i < NWORDS; i++) begin
      cur_word = (cnt == 3'(i)) ? data[64*i +: 64] : cur_word;
    end
  end

  assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN);
  assign out_state = data;

  // Next-state, counter and state-word update logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    data_nx  = data;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          data_nx  = in_state;
          cnt_nx   = 3'd0;
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NWORDS; i++) begin
          data_nx[64*i +: 64] = (cnt == 3'(i)) ? lin_out : data[64*i +: 64];
        end
        if (cnt == 3'(NWORDS - 1)) begin
          cnt_nx   = 3'd0;
          state_nx = ST_DONE;
        end else begin
          cnt_nx   = cnt + 3'd1;
        end
      end
      ST_DONE: begin
        if (out_ready && in_valid) begin
          data_nx  = in_state;
          cnt_nx   = 3'd0;
          state_nx = ST_RUN;
        end else if (out_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DONE;
        end
      end
      default: begin
        cnt_nx   = 3'd0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
      data  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      data  <= data_nx;
    end
  end

endmodule
